zombie_game_core: RTL

- Parametrised whack-a-zombie game engine for N holes (one button and one LED per hole).
- Runs a timed round:
  - pseudo-randomly lights one hole at a time;
  - counts hits, misses and timeouts;
  - raises gameover when the round timer expires.
- Sits between the board's button synchronisers and the LED/score display drivers. Successor to the fixed 3-button, 30-cycle game with no scoring.

---
 rtl/zombie_pkg.sv | 15 +
 rtl/zombie_lfsr.sv | 37 +++
 rtl/zombie_game_core.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/zombie_pkg.sv
// Shared types and constants for the whack-a-zombie engine: FSM encoding and LFSR polynomial.
// Pure declarations; no logic, latency or flow control.
package zombie_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 with a right-shifting register.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/zombie_lfsr.sv
// 16-bit Galois LFSR, one step per enabled clk; q is the registered state.
// Latency: new value one clk after en; no backpressure.
module zombie_lfsr
    import zombie_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] q
);

    // An all-zero state would lock the register, so a zero seed falls back to the default.
    localparam logic [15:0] RST_VAL = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= RST_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/zombie_game_core.sv
// Whack-a-zombie round engine: lights one hole at a time, scores hits, wrong presses and timeouts.
// Latency: outputs registered, events visible one clk after the button edge; no backpressure.
module zombie_game_core
    import zombie_pkg::*;
#(
    parameter int          N_HOLES     = 3,
    parameter int          TICK_DIV    = 50000000,
    parameter int          ROUND_TICKS = 30,
    parameter int          LIFE_TICKS  = 3,
    parameter int          SCORE_W     = 8,
    parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED,
    localparam int         IDXW        = $clog2(N_HOLES),
    localparam int         TW          = $clog2(ROUND_TICKS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_HOLES-1:0] btn,
    output logic [N_HOLES-1:0] led,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] miss,
    output logic [TW-1:0]      time_left,
    output logic               playing,
    output logic               gameover
);

    localparam int            PW     = $clog2(TICK_DIV);
    localparam int            LW     = $clog2(LIFE_TICKS + 1);
    localparam logic [IDXW:0] NH_EXT = N_HOLES[IDXW:0];

    state_e             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [LW-1:0]      life_q, life_d;
    logic               cool_q, cool_d;
    logic [N_HOLES-1:0] btn_q;
    logic [N_HOLES-1:0] led_q, led_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] miss_q, miss_d;
    logic [TW-1:0]      tleft_q, tleft_d;

    logic [15:0]        lfsr_q;
    logic               lfsr_unused;
    logic [N_HOLES-1:0] rise;
    logic               tick, hit, wrong, timeout;
    logic [IDXW-1:0]    spawn_idx;
    logic [N_HOLES-1:0] spawn_led;
    logic [1:0]         miss_inc;
    logic [SCORE_W:0]   miss_sum;

    // Free-running in every state so the player's timing perturbs which hole lights next.
    zombie_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:IDXW];

    assign rise    = btn & ~btn_q;
    assign tick    = (state_q == PLAY) && (presc_q == PW'(TICK_DIV - 1));
    assign hit     = |(rise & led_q);
    assign wrong   = |(rise & ~led_q);
    assign timeout = tick && (led_q != '0) && !hit && (life_q == LW'(1));

    always_comb begin
        spawn_idx = lfsr_q[IDXW-1:0];
        if ({1'b0, spawn_idx} >= NH_EXT) begin
            spawn_idx = spawn_idx - IDXW'(N_HOLES);
        end
        spawn_led = {{(N_HOLES-1){1'b0}}, 1'b1} << spawn_idx;
        miss_inc  = {1'b0, wrong} + {1'b0, timeout};
        miss_sum  = {1'b0, miss_q} + (SCORE_W+1)'(miss_inc);
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        life_d  = life_q;
        cool_d  = cool_q;
        led_d   = led_q;
        score_d = score_q;
        miss_d  = miss_q;
        tleft_d = tleft_q;

        case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    state_d = PLAY;
                    presc_d = '0;
                    life_d  = '0;
                    cool_d  = 1'b1;
                    led_d   = '0;
                    score_d = '0;
                    miss_d  = '0;
                    tleft_d = TW'(ROUND_TICKS);
                end
            end
            PLAY: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (hit && (score_q != '1)) begin
                    score_d = score_q + 1'b1;
                end
                miss_d = miss_sum[SCORE_W] ? '1 : miss_sum[SCORE_W-1:0];

                // A hit pre-empts the life countdown of the same cycle.
                if (hit) begin
                    led_d  = '0;
                    cool_d = 1'b1;
                end else if (tick && (led_q != '0)) begin
                    life_d = life_q - 1'b1;
                    if (timeout) begin
                        led_d  = '0;
                        cool_d = 1'b1;
                    end
                end else if (tick) begin
                    if (cool_q) begin
                        cool_d = 1'b0;
                    end else if (tleft_q > TW'(1)) begin
                        led_d  = spawn_led;
                        life_d = LW'(LIFE_TICKS);
                    end
                end

                if (tick) begin
                    tleft_d = tleft_q - 1'b1;
                    if (tleft_q == TW'(1)) begin
                        state_d = FINISH;
                        led_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            life_q  <= '0;
            cool_q  <= 1'b0;
            btn_q   <= '0;
            led_q   <= '0;
            score_q <= '0;
            miss_q  <= '0;
            tleft_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            life_q  <= life_d;
            cool_q  <= cool_d;
            btn_q   <= btn;
            led_q   <= led_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            tleft_q <= tleft_d;
        end
    end

    assign led       = led_q;
    assign score     = score_q;
    assign miss      = miss_q;
    assign time_left = tleft_q;
    assign playing   = (state_q == PLAY);
    assign gameover  = (state_q == FINISH);

endmodule
